// File: rtl/apb_node_reg.sv
// Registered APB 1-to-NB_MASTER demultiplexer with address-window decode,
// decode-error response and ACCESS-phase timeout.
module apb_node_reg #(
    parameter int NB_MASTER      = 8,
    parameter int APB_DATA_WIDTH = 32,
    parameter int APB_ADDR_WIDTH = 32,
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic                                          clk_i,
    input  logic                                          rst_ni,
    input  logic                                          psel_i,
    input  logic                                          penable_i,
    input  logic                                          pwrite_i,
    input  logic [APB_ADDR_WIDTH-1:0]                     paddr_i,
    input  logic [APB_DATA_WIDTH-1:0]                     pwdata_i,
    output logic [APB_DATA_WIDTH-1:0]                     prdata_o,
    output logic                                          pready_o,
    output logic                                          pslverr_o,
    output logic [NB_MASTER-1:0]                          psel_o,
    output logic [NB_MASTER-1:0]                          penable_o,
    output logic [NB_MASTER-1:0]                          pwrite_o,
    output logic [NB_MASTER-1:0][APB_ADDR_WIDTH-1:0]      paddr_o,
    output logic [NB_MASTER-1:0][APB_DATA_WIDTH-1:0]      pwdata_o,
    input  logic [NB_MASTER-1:0][APB_DATA_WIDTH-1:0]      prdata_i,
    input  logic [NB_MASTER-1:0]                          pready_i,
    input  logic [NB_MASTER-1:0]                          pslverr_i,
    input  logic [NB_MASTER-1:0][APB_ADDR_WIDTH-1:0]      start_addr_i,
    input  logic [NB_MASTER-1:0][APB_ADDR_WIDTH-1:0]      end_addr_i,
    output logic                                          decerr_o,
    output logic                                          timeout_o
);

    localparam int IDX_W = (NB_MASTER > 1) ? $clog2(NB_MASTER) : 1;
    localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [CNT_W-1:0] TO_VAL = CNT_W'(TIMEOUT_CYCLES);

    typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_t;

    state_t                    state_q, state_d;
    logic [IDX_W-1:0]          idx_q, idx_d, dec_idx;
    logic                      dec_hit;
    logic                      wr_q, wr_d;
    logic [APB_ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [APB_DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic                      err_q, err_d;
    logic [APB_DATA_WIDTH-1:0] rdata_q, rdata_d;
    logic [CNT_W-1:0]          cnt_q, cnt_d;
    logic                      to_fire;

    logic [NB_MASTER-1:0]                     sel_vec;
    logic [NB_MASTER-1:0]                     psel_d, penable_d, pwrite_d;
    logic [NB_MASTER-1:0][APB_ADDR_WIDTH-1:0] paddr_d;
    logic [NB_MASTER-1:0][APB_DATA_WIDTH-1:0] pwdata_d;
    logic [APB_DATA_WIDTH-1:0]                prdata_d;
    logic                                     pready_d, pslverr_d, decerr_d, timeout_d;

    // Descending scan so the lowest matching index is the one left standing
    always_comb begin
        dec_hit = 1'b0;
        dec_idx = '0;
        for (int i = NB_MASTER - 1; i >= 0; i--) begin
            if ((start_addr_i[i] <= paddr_i) && (paddr_i <= end_addr_i[i])) begin
                dec_hit = 1'b1;
                dec_idx = IDX_W'(i);
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            idx_q   <= '0;
            wr_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            err_q   <= 1'b0;
            rdata_q <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            wr_q    <= wr_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            err_q   <= err_d;
            rdata_q <= rdata_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        wr_d    = wr_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        err_d   = err_q;
        rdata_d = rdata_q;
        cnt_d   = cnt_q;
        to_fire = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (psel_i && !penable_i) begin
                    wr_d    = pwrite_i;
                    addr_d  = paddr_i;
                    wdata_d = pwdata_i;
                    idx_d   = dec_idx;
                    rdata_d = '0;
                    err_d   = !dec_hit;
                    state_d = dec_hit ? SETUP : RESP;
                end
            end
            SETUP: begin
                cnt_d   = CNT_W'(1);
                state_d = ACCESS;
            end
            ACCESS: begin
                if (pready_i[idx_q]) begin
                    rdata_d = wr_q ? '0 : prdata_i[idx_q];
                    err_d   = pslverr_i[idx_q];
                    state_d = RESP;
                end else if ((TIMEOUT_CYCLES != 0) && (cnt_q == TO_VAL)) begin
                    to_fire = 1'b1;
                    rdata_d = '0;
                    err_d   = 1'b1;
                    state_d = RESP;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            RESP: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Outputs are computed from the next state so every port comes straight off a flop
    always_comb begin
        for (int i = 0; i < NB_MASTER; i++) begin
            sel_vec[i] = (idx_d == IDX_W'(i));
        end
        psel_d    = '0;
        penable_d = '0;
        pwrite_d  = '0;
        paddr_d   = '0;
        pwdata_d  = '0;
        if ((state_d == SETUP) || (state_d == ACCESS)) begin
            psel_d    = sel_vec;
            penable_d = (state_d == ACCESS) ? sel_vec : '0;
            for (int i = 0; i < NB_MASTER; i++) begin
                if (sel_vec[i]) begin
                    pwrite_d[i] = wr_d;
                    paddr_d[i]  = addr_d;
                    pwdata_d[i] = wdata_d;
                end
            end
        end
        pready_d  = (state_d == RESP);
        pslverr_d = (state_d == RESP) && err_d;
        prdata_d  = (state_d == RESP) ? rdata_d : '0;
        decerr_d  = (state_q == IDLE) && (state_d == RESP);
        timeout_d = to_fire;
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            psel_o    <= '0;
            penable_o <= '0;
            pwrite_o  <= '0;
            paddr_o   <= '0;
            pwdata_o  <= '0;
            prdata_o  <= '0;
            pready_o  <= 1'b0;
            pslverr_o <= 1'b0;
            decerr_o  <= 1'b0;
            timeout_o <= 1'b0;
        end else begin
            psel_o    <= psel_d;
            penable_o <= penable_d;
            pwrite_o  <= pwrite_d;
            paddr_o   <= paddr_d;
            pwdata_o  <= pwdata_d;
            prdata_o  <= prdata_d;
            pready_o  <= pready_d;
            pslverr_o <= pslverr_d;
            decerr_o  <= decerr_d;
            timeout_o <= timeout_d;
        end
    end

endmodule
